sync_debounce: RTL and testbench

- Multi-channel input conditioner for asynchronous, mechanically bouncy inputs: labkit buttons, switches, and external trigger lines.
- Each channel passes through an NSYNC-flop synchroniser, then a per-channel debounce counter.
- Produces a debounced level per channel and single-cycle rise/fall strobes.
- Sits between the top-level pins and every FSM that consumes user inputs; replaces ad-hoc per-input synchroniser and debounce logic.

---
 rtl/sync_pkg.sv | 25 ++
 rtl/sync_debounce_ch.sv | 83 ++++++++
 rtl/sync_debounce.sv | 38 +++
 tb/tb_sync_debounce.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared constants and helpers for the sync_debounce input conditioner.
package sync_pkg;

   // 10 ms at 65 MHz: the default debounce window for mechanical contacts.
   localparam int DB_10MS_65MHZ = 650000;

   // Short debounce window used for simulation builds.
   localparam int DB_SIM = 4;

   // Ceiling log2 for sizing counters from elaboration-time constants.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      for (int i = 0; i < 32; i++) begin
         if (v > 0) begin
            result = result + 1;
            v = v >> 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// One input channel: NSYNC-flop synchroniser, debounce counter, debounced
// level and optional rise/fall strobes (enabled by SYNC_DEBOUNCE_EDGE_EN).
module debounce_ch
   import sync_pkg::*;
#(
   parameter int   NSYNC     = 2,
   parameter int   DB_CYCLES = DB_SIM,
   parameter logic INIT      = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic sync_out,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int            CW   = clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

   logic [NSYNC-1:0] r_sync;
   logic [CW-1:0]    r_cnt;
   logic             r_level;
   logic             w_sync;
   logic             w_disagree;
   logic             w_done;

   assign w_sync     = r_sync[NSYNC-1];
   assign w_disagree = w_sync ^ r_level;
   // The counter never passes LAST, so it cannot wrap.
   assign w_done     = w_disagree && (r_cnt == LAST);

   // Shift the raw input through the synchroniser chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= {NSYNC{INIT}};
      end else begin
         r_sync <= {r_sync[NSYNC-2:0], in};
      end
   end

   // Count consecutive disagreeing cycles; any agreement restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_level <= INIT;
      end else if (!w_disagree) begin
         r_cnt   <= '0;
      end else if (w_done) begin
         r_cnt   <= '0;
         r_level <= w_sync;
      end else begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   assign sync_out = w_sync;
   assign level    = r_level;

`ifdef SYNC_DEBOUNCE_EDGE_EN
   logic r_rise;
   logic r_fall;

   // Strobe in the same cycle the debounced level first shows its new value.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_done & w_sync;
         r_fall <= w_done & ~w_sync;
      end
   end

   assign rise = r_rise;
   assign fall = r_fall;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchroniser + debouncer for asynchronous bouncy inputs.
// Rise/fall strobes exist only when SYNC_DEBOUNCE_EDGE_EN is defined;
// otherwise they are tied low. This level only slices the buses.
module sync_debounce
   import sync_pkg::*;
#(
   parameter int   NCH       = 4,
   parameter int   NSYNC     = 2,
   parameter int   DB_CYCLES = DB_10MS_65MHZ,
   parameter logic INIT      = 1'b0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [NCH-1:0] in,
   output logic [NCH-1:0] sync_out,
   output logic [NCH-1:0] level,
   output logic [NCH-1:0] rise,
   output logic [NCH-1:0] fall
);

   // One fully independent conditioner per channel.
   for (genvar g = 0; g < NCH; g++) begin : g_ch
      debounce_ch #(
         .NSYNC     (NSYNC),
         .DB_CYCLES (DB_CYCLES),
         .INIT      (INIT)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .in       (in[g]),
         .sync_out (sync_out[g]),
         .level    (level[g]),
         .rise     (rise[g]),
         .fall     (fall[g])
      );
   end

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce (NCH=4, NSYNC=2, DB_CYCLES=4, INIT=0).
// Strobe expectations are forced to zero when SYNC_DEBOUNCE_EDGE_EN is
// undefined, which exercises the strobe-less build.
module tb_sync_debounce;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] in = 4'hF;
   logic [3:0] sync_out;
   logic [3:0] level;
   logic [3:0] rise;
   logic [3:0] fall;

   always #5 clk = ~clk;

   sync_debounce #(
      .NCH       (4),
      .NSYNC     (2),
      .DB_CYCLES (4),
      .INIT      (1'b0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in       (in),
      .sync_out (sync_out),
      .level    (level),
      .rise     (rise),
      .fall     (fall)
   );

   typedef struct packed {
      logic [31:0] cyc;
      logic        chk_sync;
      logic [3:0]  so;
      logic [3:0]  lvl;
      logic [3:0]  rs;
      logic [3:0]  fl;
   } exp_t;

   exp_t  q[$];
   string nq[$];
   int    cyc = 0;
   int    n_vec = 0;
   int    n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Drive one vector; expectation applies to outputs after the next edge.
   task automatic step(input logic r, input logic [3:0] i, input logic cs,
                       input logic [3:0] so, input logic [3:0] lvl,
                       input logic [3:0] rs, input logic [3:0] fl,
                       input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset = r;
      in    = i;
`ifndef SYNC_DEBOUNCE_EDGE_EN
      rs = 4'h0;
      fl = 4'h0;
`endif
      e.cyc      = cyc + 1;
      e.chk_sync = cs;
      e.so       = so;
      e.lvl      = lvl;
      e.rs       = rs;
      e.fl       = fl;
      q.push_back(e);
      nq.push_back(nm);
   endtask

   // Clean transition applied before edge 0: sync_out moves after edge 1,
   // level and strobes after edge 5 (NSYNC-1 + DB_CYCLES).
   task automatic settle(input logic [3:0] old_so, input logic [3:0] new_in,
                         input logic [3:0] old_lvl, input string nm);
      for (int k = 0; k < 7; k++) begin
         step(1'b0, new_in, 1'b1,
              (k >= 1) ? new_in : old_so,
              (k >= 5) ? new_in : old_lvl,
              (k == 5) ? (new_in & ~old_lvl) : 4'h0,
              (k == 5) ? (old_lvl & ~new_in) : 4'h0,
              nm);
      end
   endtask

   // Monitor: compare outputs every cycle against the scoreboard head.
   always @(negedge clk) begin
      if (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t  e;
         string nm;
         logic  bad;
         e  = q.pop_front();
         nm = nq.pop_front();
         n_vec++;
         bad = (e.cyc != cyc) || (level !== e.lvl) || (rise !== e.rs) ||
               (fall !== e.fl) || (e.chk_sync && (sync_out !== e.so));
         if (bad) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got so=%b lvl=%b rise=%b fall=%b, required so=%b lvl=%b rise=%b fall=%b (for cyc %0d)",
                     nm, cyc, sync_out, level, rise, fall, e.so, e.lvl, e.rs, e.fl, e.cyc);
         end
      end
   end

   initial begin
      // 1: reset held with inputs high, then the post-release transition.
      for (int k = 0; k < 3; k++) step(1'b1, 4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "rst_hold");
      settle(4'h0, 4'hF, 4'h0, "rst_release");

      // 2: return to zero via reset, then a clean step on channel 0.
      for (int k = 0; k < 2; k++) step(1'b1, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "rst_zero");
      for (int k = 0; k < 2; k++) step(1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "idle");
      settle(4'h0, 4'h1, 4'h0, "clean_step");

      // 3: channel 1 bounces 1-high/2-low, then rests low; level must not move.
      for (int i = 0; i < 46; i++) begin
         logic b_now;
         logic b_prev;
         b_now  = (i < 40) && (i % 3 == 0);
         b_prev = (i >= 1) && (i - 1 < 40) && ((i - 1) % 3 == 0);
         step(1'b0, {2'b00, b_now, 1'b1}, 1'b1, {2'b00, b_prev, 1'b1},
              4'h1, 4'h0, 4'h0, "bounce");
      end

      // 4: move to 4'b1000, then swap to 4'b0100 in one cycle.
      settle(4'h1, 4'h8, 4'h1, "to_1000");
      settle(4'h8, 4'h4, 4'h8, "simultaneous");

      // 5: reset pulsed while channel 0 is at count 3.
      settle(4'h4, 4'h0, 4'h4, "to_zero");
      for (int k = 0; k < 5; k++)
         step(1'b0, 4'h1, 1'b1, (k >= 1) ? 4'h1 : 4'h0, 4'h0, 4'h0, 4'h0, "partial");
      step(1'b1, 4'h1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "mid_reset");
      settle(4'h0, 4'h1, 4'h0, "after_mid_reset");

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 4 && q.size() > 0; k++) @(posedge clk);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
